seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector with Moore-style registered output. It generalises the team's fixed 4-bit sequence detectors to any pattern length and makes three things configurable: the pattern (reset value plus runtime reload), overlapping or non-overlapping matching, and a saturating match counter. It sits on a serial bit stream that is qualified by an enable, and it flags each complete occurrence of the pattern.

## Interface
- SEQ_LEN, 4: pattern length in bits, 2..32.
- PATTERN, 4'b1011: pattern loaded at reset, SEQ_LEN bits wide. MSB is the first bit received.
- OVERLAP, 0: 1 = overlapping detection, 0 = non-overlapping detection.
- CNT_W, 8: width of the match counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  bit-valid qualifier. x is sampled only when en=1.
- x  in  1  serial data bit.
- pat_load  in  1  load strobe: on this edge, the pattern register takes pat_in.
- pat_in  in  SEQ_LEN  new pattern, MSB-first order.
- z  out  1  match flag, registered.
- match_count  out  CNT_W  number of matches since reset, saturating.
- pattern  out  SEQ_LEN  current pattern register.

## Operation
- State:
  - pattern register.
  - history shift register hist[SEQ_LEN-1:0]: new bit enters at the LSB, oldest bit sits at the MSB.
  - fill counter (0..SEQ_LEN): number of valid bits accepted since the last clear. It saturates at SEQ_LEN.
  - z register.
  - match_count register.
- Accepted bit: a bit is accepted on an edge with en=1, rst=0 and pat_load=0.
- Match: on an accepting edge, a match occurs if both hold after the new bit is shifted in:
  - {hist[SEQ_LEN-2:0], x} == pattern;
  - fill+1 >= SEQ_LEN.
- On a match:
  - z is set to 1.
  - match_count increments unless it is already all-ones, in which case it holds.
  - OVERLAP=0: fill clears to 0, so no bit of a matched occurrence is reused.
  - OVERLAP=1: fill stays at SEQ_LEN, so the tail of a match can start the next one.
- On an accepting edge with no match: z is set to 0 and fill increments (saturating at SEQ_LEN).
- Edge with en=0 (no load, no reset): hist, fill and match_count hold, and z clears to 0. z is therefore never high for more than one cycle per match.
- pat_load=1 (rst=0):
  - pattern <= pat_in.
  - fill <= 0, hist <= 0 and z <= 0.
  - x is not sampled on that edge, even if en=1.
  - match_count holds.
- rst=1: takes priority over everything else.
  - pattern <= PATTERN.
  - hist, fill and match_count are cleared to 0.
  - z is cleared to 0.
- Equivalent state-machine view: one "progress" state per prefix length 0..SEQ_LEN-1, plus a MATCH state that asserts z. The shift-register-and-fill formulation above is normative. Either implementation is acceptable if it is cycle-identical to it.

## Timing
- Reset values:
  - z = 0.
  - match_count = 0.
  - pattern = PATTERN.
- Latency: z rises in the cycle immediately after the edge that accepts the last pattern bit, and it is high for exactly one cycle.
- match_count updates on the same edge that sets z.
- Back-to-back matches are possible only when OVERLAP=1 and the pattern's own structure allows it. In that case z stays high for consecutive cycles, one cycle per match.
- With OVERLAP=0, a second match needs at least SEQ_LEN further accepted bits.
- Reset in the middle of a sequence discards all partial progress. The first possible match then comes SEQ_LEN accepted bits after rst deasserts.
- Counter wrap: none. The counter saturates at 2^CNT_W-1.
- pattern output changes on the edge after a pat_load or rst.

## Test plan
- Non-overlap: defaults (1011, OVERLAP=0), en=1, x stream 1,0,1,1,0,1,1 → z=1 only after bit 4; match_count=1 at the end.
- Overlap: OVERLAP=1, same stream 1,0,1,1,0,1,1 → z=1 after bit 4 and after bit 7; match_count=2. Also PATTERN=4'b1111 with stream 1,1,1,1,1,1 → z high for 3 consecutive cycles, after bits 4, 5 and 6.
- Enable gaps: stream 1,0,1,1 with en=0 for 3 cycles between every pair of bits → exactly one z pulse, one cycle after the final accepted 1; z=0 during all en=0 cycles.
- Runtime reload: stream 1,0,1, then pat_load with pat_in=4'b0110 (en=1, x=1 on that edge), then stream 0,1,1,0 → pattern reads 0110; no match before the load; z=1 after the 4th post-load bit.
- Reset mid-sequence: stream 1,0,1, then rst for 1 cycle, then x=1 → no z. Then 0,1,1 → z=1. match_count = 1 after the reset.
- Saturation: CNT_W=2, OVERLAP=0, stream 1011 repeated 5 times → five z pulses; match_count goes 1,2,3,3,3.

Source files
------------

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial bit-pattern detector with a registered (Moore-style) match flag.
// Bits arrive MSB-first on x, qualified by en. A history shift register plus
// a fill counter decide when the most recent SEQ_LEN accepted bits equal the
// pattern register. Each match pulses z for one cycle and bumps a saturating
// match counter. The pattern can be reloaded at run time through pat_load.
//
// Parameters
//   SEQ_LEN  pattern length in bits (2..32)
//   PATTERN  pattern loaded on reset, MSB is the first bit received
//   OVERLAP  1: the tail of a match may begin the next one
//            0: a match consumes all of its bits
//   CNT_W    width of the saturating match counter
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high, overrides everything
//   en           bit-valid qualifier for x
//   x            serial data bit
//   pat_load     load strobe, pattern takes pat_in and progress is discarded
//   pat_in       new pattern, MSB-first
//   z            registered match flag, one cycle per match
//   match_count  matches since reset, saturates at all-ones
//   pattern      current pattern register
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pat_in,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [SEQ_LEN-1:0] pattern
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);

    logic [SEQ_LEN-1:0] pattern_reg, pattern_next;
    logic [SEQ_LEN-1:0] hist_reg,    hist_next;
    logic [FILL_W-1:0]  fill_reg,    fill_next;
    logic               z_reg,       z_next;
    logic [CNT_W-1:0]   count_reg,   count_next;

    logic [SEQ_LEN-1:0] shifted;
    logic               hit;

    // History as it would look once the current bit is shifted in.
    assign shifted = {hist_reg[SEQ_LEN-2:0], x};

    // A match needs the window to equal the pattern and the window to be
    // made entirely of bits accepted since the last clear (fill+1 >= SEQ_LEN).
    assign hit = (shifted == pattern_reg) && (fill_reg >= FILL_LAST);

    always_comb begin
        pattern_next = pattern_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        z_next       = 1'b0;
        count_next   = count_reg;

        if (pat_load) begin
            // Reload discards all progress; x is ignored on this edge.
            pattern_next = pat_in;
            hist_next    = '0;
            fill_next    = '0;
        end else if (en) begin
            hist_next = shifted;
            if (hit) begin
                z_next = 1'b1;
                if (!(&count_reg)) begin
                    count_next = count_reg + 1'b1;
                end
                // Overlapping mode keeps the window valid so its tail can be
                // reused; non-overlapping mode starts over from scratch.
                fill_next = OVERLAP ? FILL_MAX : '0;
            end else if (fill_reg != FILL_MAX) begin
                fill_next = fill_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_reg <= PATTERN;
            hist_reg    <= '0;
            fill_reg    <= '0;
            z_reg       <= 1'b0;
            count_reg   <= '0;
        end else begin
            pattern_reg <= pattern_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            z_reg       <= z_next;
            count_reg   <= count_next;
        end
    end

    assign z           = z_reg;
    assign match_count = count_reg;
    assign pattern     = pattern_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Directed bench for seq_detect_param. Four instances share one stimulus bus:
//   dut      defaults (1011, non-overlapping, 8-bit counter)
//   dut_ov   1011, overlapping
//   dut_ones 1111, overlapping
//   dut_sat  1011, non-overlapping, 2-bit counter
// Each test resets all of them first and checks the instance it targets.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;

    logic       z_a, z_b, z_c, z_d;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_d;
    logic [3:0] pat_a, pat_b, pat_c, pat_d;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .z(z_a), .match_count(cnt_a), .pattern(pat_a)
    );

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .z(z_b), .match_count(cnt_b), .pattern(pat_b)
    );

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) dut_ones (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .z(z_c), .match_count(cnt_c), .pattern(pat_c)
    );

    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .pat_load(pat_load), .pat_in(pat_in),
        .z(z_d), .match_count(cnt_d), .pattern(pat_d)
    );

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one valid bit for exactly one edge.
    task automatic send_bit(input logic b);
        en = 1'b1;
        x  = b;
        step();
        en = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        pat_load = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        x  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b0;
        checks++;
        if (z_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_z got=%b exp=0", z_a);
        end
        checks++;
        if (cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", cnt_a);
        end
        checks++;
        if (pat_a !== 4'b1011) begin
            failures++;
            $display("FAIL reset_pattern got=%b exp=1011", pat_a);
        end
        checks++;
        if (pat_c !== 4'b1111) begin
            failures++;
            $display("FAIL reset_pattern_ones got=%b exp=1111", pat_c);
        end
        $display("test_reset: z=%b count=%0d pattern=%b", z_a, cnt_a, pat_a);
    endtask

    // Stream 1011011: non-overlap matches once, overlap matches twice.
    task automatic test_overlap_vs_non();
        logic [6:0] stream;
        logic [6:0] exp_no;
        logic [6:0] exp_ov;
        stream = 7'b1011011;
        exp_no = 7'b0001000;
        exp_ov = 7'b0001001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z_a !== exp_no[i]) begin
                failures++;
                $display("FAIL nonov_z bit%0d got=%b exp=%b", 7 - i, z_a, exp_no[i]);
            end
            checks++;
            if (z_b !== exp_ov[i]) begin
                failures++;
                $display("FAIL ov_z bit%0d got=%b exp=%b", 7 - i, z_b, exp_ov[i]);
            end
            $display("stream bit%0d x=%b z_nonov=%b z_ov=%b", 7 - i, stream[i], z_a, z_b);
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL nonov_count got=%0d exp=1", cnt_a);
        end
        checks++;
        if (cnt_b !== 8'd2) begin
            failures++;
            $display("FAIL ov_count got=%0d exp=2", cnt_b);
        end
    endtask

    // 1111 with overlap on six ones: z high for three consecutive cycles.
    task automatic test_back_to_back();
        logic [5:0] exp_z;
        exp_z = 6'b000111;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            send_bit(1'b1);
            checks++;
            if (z_c !== exp_z[i]) begin
                failures++;
                $display("FAIL b2b_z bit%0d got=%b exp=%b", 6 - i, z_c, exp_z[i]);
            end
            $display("b2b bit%0d z=%b count=%0d", 6 - i, z_c, cnt_c);
        end
        checks++;
        if (cnt_c !== 8'd3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", cnt_c);
        end
        step();
        checks++;
        if (z_c !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_z got=%b exp=0", z_c);
        end
    endtask

    // 1,0,1,1 with three idle cycles after every bit.
    task automatic test_enable_gaps();
        logic [3:0] stream;
        stream = 4'b1011;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z_a !== (i == 0)) begin
                failures++;
                $display("FAIL gap_z_accept bit%0d got=%b exp=%b", 4 - i, z_a, (i == 0));
            end
            $display("gap bit%0d x=%b z=%b", 4 - i, stream[i], z_a);
            for (int g = 0; g < 3; g++) begin
                x = ~x;
                step();
                checks++;
                if (z_a !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_z_idle bit%0d gap%0d got=%b exp=0", 4 - i, g, z_a);
                end
            end
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=1", cnt_a);
        end
    endtask

    task automatic test_reload();
        logic [3:0] post;
        post = 4'b0110;
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if (z_a !== 1'b0) begin
            failures++;
            $display("FAIL reload_pre_z got=%b exp=0", z_a);
        end
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        en       = 1'b1;
        x        = 1'b1;
        step();
        pat_load = 1'b0;
        en       = 1'b0;
        checks++;
        if (pat_a !== 4'b0110) begin
            failures++;
            $display("FAIL reload_pattern got=%b exp=0110", pat_a);
        end
        checks++;
        if (z_a !== 1'b0) begin
            failures++;
            $display("FAIL reload_load_z got=%b exp=0", z_a);
        end
        $display("reload: pattern=%b z=%b", pat_a, z_a);
        for (int i = 3; i >= 0; i--) begin
            send_bit(post[i]);
            checks++;
            if (z_a !== (i == 0)) begin
                failures++;
                $display("FAIL reload_z bit%0d got=%b exp=%b", 4 - i, z_a, (i == 0));
            end
            $display("reload bit%0d x=%b z=%b", 4 - i, post[i], z_a);
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL reload_count got=%0d exp=1", cnt_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] stream;
        logic [3:0] exp_z;
        stream = 4'b1011;
        exp_z  = 4'b0001;
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        en  = 1'b1;
        x   = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b0;
        checks++;
        if (z_a !== 1'b0 || cnt_a !== 8'd0) begin
            failures++;
            $display("FAIL midrst_state got z=%b count=%0d exp z=0 count=0", z_a, cnt_a);
        end
        for (int i = 3; i >= 0; i--) begin
            send_bit(stream[i]);
            checks++;
            if (z_a !== exp_z[i]) begin
                failures++;
                $display("FAIL midrst_z bit%0d got=%b exp=%b", 4 - i, z_a, exp_z[i]);
            end
            $display("midrst bit%0d x=%b z=%b", 4 - i, stream[i], z_a);
        end
        checks++;
        if (cnt_a !== 8'd1) begin
            failures++;
            $display("FAIL midrst_count got=%0d exp=1", cnt_a);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] stream;
        logic [1:0] exp_cnt [5];
        stream = 4'b1011;
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3;
        exp_cnt[4] = 2'd3;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 3; i >= 0; i--) begin
                send_bit(stream[i]);
                checks++;
                if (z_d !== (i == 0)) begin
                    failures++;
                    $display("FAIL sat_z rep%0d bit%0d got=%b exp=%b", r, 4 - i, z_d, (i == 0));
                end
            end
            checks++;
            if (cnt_d !== exp_cnt[r]) begin
                failures++;
                $display("FAIL sat_count rep%0d got=%0d exp=%0d", r, cnt_d, exp_cnt[r]);
            end
            $display("sat rep%0d z=%b count=%0d", r, z_d, cnt_d);
        end
    endtask

    initial begin
        test_reset();
        test_overlap_vs_non();
        test_back_to_back();
        test_enable_gaps();
        test_reload();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
